// File: rtl/ram_arbiter.sv
// Time-sliced arbiter sharing one synchronous SoC RAM between the 65xx CPU and a DMA requester.
// The CPU owns the RAM by default; DMA steals bursts of up to DMA_BURST cycles, separated by CPU_SLICE CPU cycles.
module ram_arbiter #(
  parameter int AW        = 16,
  parameter int DMA_BURST = 4,
  parameter int CPU_SLICE = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_we,
  input  logic [7:0]    dma_wdata,
  output logic          dma_gnt,
  output logic [7:0]    dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam int CW = $clog2(CPU_SLICE + 1);
  localparam int BW = $clog2(DMA_BURST + 1);
  localparam logic [CW-1:0] CPU_LAST   = CW'(CPU_SLICE - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(DMA_BURST - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cpu_cnt_r;
  logic [BW-1:0] burst_cnt_r;
  logic          last_cpu_r;
  logic [7:0]    hold_r;
  logic          dma_rvalid_r;
  logic          own_dma_s;
  logic          we_s;

  assign own_dma_s = (state_r == S_DMA);

  // Ownership FSM: every grant decision is taken at an edge and applies from the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_CPU;
      cpu_cnt_r   <= {CW{1'b0}};
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      case (state_r)
        S_CPU: begin
          if (cpu_cnt_r != CPU_LAST) begin
            cpu_cnt_r <= cpu_cnt_r + CW'(1);
          end
          if (dma_req && (cpu_cnt_r == CPU_LAST)) begin
            state_r     <= S_DMA;
            burst_cnt_r <= {BW{1'b0}};
          end
        end
        S_DMA: begin
          // A dropped request ends the burst; the idle cycle is the price of registered ownership.
          if (!dma_req) begin
            state_r   <= S_CPU;
            cpu_cnt_r <= {CW{1'b0}};
          end else if (burst_cnt_r == BURST_LAST) begin
            state_r   <= S_CPU;
            cpu_cnt_r <= {CW{1'b0}};
          end else begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r     <= S_CPU;
          cpu_cnt_r   <= {CW{1'b0}};
          burst_cnt_r <= {BW{1'b0}};
        end
      endcase
    end
  end

  // Read-return tracking: remember who read last and freeze the CPU's data while DMA owns the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cpu_r   <= 1'b1;
      hold_r       <= 8'h00;
      dma_rvalid_r <= 1'b0;
    end else begin
      last_cpu_r   <= ~own_dma_s;
      dma_rvalid_r <= own_dma_s & dma_req & ~dma_we;
      if (last_cpu_r) begin
        hold_r <= mem_rdata;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // RAM port mux; the write enable is also gated by reset so nothing is written while in reset.
  always_comb begin
    if (own_dma_s) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      we_s      = dma_req & dma_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      we_s      = cpu_we;
    end
    mem_we = reset_n & we_s;
  end

  // CPU read data: live RAM data after a CPU cycle, otherwise the last value the CPU read.
  always_comb begin
    if (last_cpu_r) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = hold_r;
    end
  end

  assign cpu_rdy    = ~own_dma_s;
  assign dma_gnt    = own_dma_s;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = dma_rvalid_r;

endmodule
